// File: rtl/video_sig_pkg.sv
// Shared types and constants for the frame-signature block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_sig_pkg;

    // Capture FSM: idle until a frame start, then hash frames back to back.
    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        CAPTURE   = 1'b1
    } state_t;

    // Bit positions inside sig_geom_err.
    localparam int ERR_LINE_LEN = 0;
    localparam int ERR_LINE_CNT = 1;
    localparam int ERR_SAT      = 2;

    // CRC-32/MPEG-2: non-reflected, all-ones seed, no final XOR.
    localparam logic [31:0] DEF_CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] DEF_CRC_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/video_frame_signature_if.sv
// Result channel of the frame-signature block (valid/ready).
// Latency: n/a (wiring only).
// Backpressure: producer holds all fields stable while sig_valid && !sig_ready.
interface video_frame_signature_if #(
    parameter int PCW = 20,
    parameter int LCW = 10
);
    logic           sig_valid;
    logic           sig_ready;
    logic [31:0]    sig_crc;
    logic [PCW-1:0] sig_pixels;
    logic [LCW-1:0] sig_lines;
    logic [2:0]     sig_geom_err;

    modport master (
        output sig_valid, sig_crc, sig_pixels, sig_lines, sig_geom_err,
        input  sig_ready
    );

    modport slave (
        input  sig_valid, sig_crc, sig_pixels, sig_lines, sig_geom_err,
        output sig_ready
    );
endinterface

// File: rtl/crc_par_update.sv
// Advances a CRC-32 register over DATA_W data bits, MSB first, shift-left form.
// Latency: purely combinational.
// Backpressure: none.
module crc_par_update #(
    parameter int          DATA_W = 12,
    parameter logic [31:0] POLY   = 32'h04C1_1DB7
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc_out
);

    // Unrolled bit-serial update: feedback is crc MSB xor the incoming data bit.
    always_comb begin
        crc_out = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (crc_out[31] ^ data[i]) begin
                crc_out = {crc_out[30:0], 1'b0} ^ POLY;
            end else begin
                crc_out = {crc_out[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/video_frame_signature.sv
// Per-frame CRC-32, pixel/line counts and geometry checks on the internal pixel stream.
// Latency: result registered on the edge that samples the vs falling edge, visible next cycle.
// Backpressure: one result held while sig_ready is low; a newer result is dropped and overrun latches.
module video_frame_signature
    import video_sig_pkg::*;
#(
    parameter int          NUM_CH   = 3,
    parameter int          CH_WIDTH = 4,
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter logic [31:0] CRC_POLY = DEF_CRC_POLY,
    parameter logic [31:0] CRC_INIT = DEF_CRC_INIT
) (
    input  logic                       pixel_clk,
    input  logic                       arstn,
    input  logic                       enable,
    input  logic [NUM_CH*CH_WIDTH-1:0] pixel_data,
    input  logic                       pixel_vde,
    input  logic                       pixel_vs,
    video_frame_signature_if.master    sig,
    output logic                       overrun
);

    localparam int PIX_W = NUM_CH * CH_WIDTH;
    localparam int PCW   = $clog2(H_ACTIVE * V_ACTIVE + 1) + 1;
    localparam int LCW   = $clog2(V_ACTIVE + 1) + 1;
    localparam int LLW   = $clog2(H_ACTIVE + 1) + 1;

    state_t         state;
    logic           vs_q;
    logic           vde_q;
    logic           frame_edge;
    logic           line_end;
    logic [31:0]    crc_q;
    logic [31:0]    crc_base;
    logic [31:0]    crc_next;
    logic [PCW-1:0] pix_cnt;
    logic [LLW-1:0] llen;
    logic [LCW-1:0] line_cnt;
    logic [LCW-1:0] close_lines;
    logic [2:0]     close_err;
    logic           err_len;
    logic           err_sat;
    logic           new_result;

    logic           out_vld;
    logic [31:0]    out_crc;
    logic [PCW-1:0] out_pixels;
    logic [LCW-1:0] out_lines;
    logic [2:0]     out_err;

    assign frame_edge = vs_q & ~pixel_vs;
    assign line_end   = vde_q & ~pixel_vde;
    assign new_result = (state == CAPTURE) && frame_edge;

    // A pixel on the frame-edge cycle starts the new frame, so hash it from the seed.
    assign crc_base = frame_edge ? CRC_INIT : crc_q;

    crc_par_update #(
        .DATA_W (PIX_W),
        .POLY   (CRC_POLY)
    ) u_crc (
        .crc_in  (crc_base),
        .data    (pixel_data),
        .crc_out (crc_next)
    );

    // Delayed copies of vs/vde for edge detection.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            vs_q  <= 1'b1;
            vde_q <= 1'b0;
        end else begin
            vs_q  <= pixel_vs;
            vde_q <= pixel_vde;
        end
    end

    // Closing view of the frame: a line still open at the frame edge is counted and checked.
    always_comb begin
        close_lines = line_cnt;
        if (vde_q && !(&line_cnt)) begin
            close_lines = line_cnt + LCW'(1);
        end
        close_err               = '0;
        close_err[ERR_LINE_LEN] = err_len | (vde_q && (llen != LLW'(H_ACTIVE)));
        close_err[ERR_LINE_CNT] = (close_lines != LCW'(V_ACTIVE));
        close_err[ERR_SAT]      = err_sat;
    end

    // Capture FSM and frame accumulators.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            state    <= WAIT_SYNC;
            crc_q    <= CRC_INIT;
            pix_cnt  <= '0;
            llen     <= '0;
            line_cnt <= '0;
            err_len  <= 1'b0;
            err_sat  <= 1'b0;
        end else begin
            case (state)
                WAIT_SYNC: begin
                    if (frame_edge && enable) begin
                        state   <= CAPTURE;
                        crc_q   <= pixel_vde ? crc_next : CRC_INIT;
                        pix_cnt <= PCW'(pixel_vde);
                        llen    <= LLW'(pixel_vde);
                    end
                end
                CAPTURE: begin
                    if (frame_edge) begin
                        line_cnt <= '0;
                        err_len  <= 1'b0;
                        err_sat  <= 1'b0;
                        if (enable) begin
                            crc_q   <= pixel_vde ? crc_next : CRC_INIT;
                            pix_cnt <= PCW'(pixel_vde);
                            llen    <= LLW'(pixel_vde);
                        end else begin
                            state   <= WAIT_SYNC;
                            crc_q   <= CRC_INIT;
                            pix_cnt <= '0;
                            llen    <= '0;
                        end
                    end else if (pixel_vde) begin
                        crc_q <= crc_next;
                        if (&pix_cnt) begin
                            err_sat <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + PCW'(1);
                        end
                        if (!(&llen)) begin
                            llen <= llen + LLW'(1);
                        end
                    end else if (line_end) begin
                        if (!(&line_cnt)) begin
                            line_cnt <= line_cnt + LCW'(1);
                        end
                        if (llen != LLW'(H_ACTIVE)) begin
                            err_len <= 1'b1;
                        end
                        llen <= '0;
                    end
                end
                default: state <= WAIT_SYNC;
            endcase
        end
    end

    // Single-entry result register with drop-newest on backpressure.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            out_vld    <= 1'b0;
            out_crc    <= '0;
            out_pixels <= '0;
            out_lines  <= '0;
            out_err    <= '0;
            overrun    <= 1'b0;
        end else if (new_result && (!out_vld || sig.sig_ready)) begin
            out_vld    <= 1'b1;
            out_crc    <= crc_q;
            out_pixels <= pix_cnt;
            out_lines  <= close_lines;
            out_err    <= close_err;
        end else if (new_result) begin
            overrun <= 1'b1;
        end else if (out_vld && sig.sig_ready) begin
            out_vld <= 1'b0;
        end
    end

    assign sig.sig_valid    = out_vld;
    assign sig.sig_crc      = out_crc;
    assign sig.sig_pixels   = out_pixels;
    assign sig.sig_lines    = out_lines;
    assign sig.sig_geom_err = out_err;

endmodule

// File: tb/tb_video_frame_signature.sv
// Drives raster frames into two signature blocks and checks results against a frame-level model.
// Latency: n/a.
// Backpressure: sig_ready is held low until each result is checked.
module tb_video_frame_signature;

    // Instance A: 8-bit single-channel pixels, 9x1 raster.
    localparam int A_H = 9;
    localparam int A_V = 1;
    // Instance B: 3x4-bit pixels on a reduced 16x12 raster.
    localparam int B_H = 16;
    localparam int B_V = 12;

    logic        pixel_clk = 1'b0;
    logic        arstn;
    logic        enable;
    logic        vde;
    logic        vs;
    logic        rdy;
    logic [11:0] pd;
    int          dsel;

    logic a_vde, a_vs, a_ovr;
    logic b_vde, b_vs, b_ovr;

    video_frame_signature_if #(.PCW(5), .LCW(2)) a_if ();
    video_frame_signature_if #(.PCW(9), .LCW(5)) b_if ();

    assign a_vde = (dsel == 0) & vde;
    assign a_vs  = (dsel == 0) ? vs : 1'b1;
    assign b_vde = (dsel == 1) & vde;
    assign b_vs  = (dsel == 1) ? vs : 1'b1;
    assign a_if.sig_ready = (dsel == 0) & rdy;
    assign b_if.sig_ready = (dsel == 1) & rdy;

    always #5 pixel_clk = ~pixel_clk;

    video_frame_signature #(
        .NUM_CH(1), .CH_WIDTH(8), .H_ACTIVE(A_H), .V_ACTIVE(A_V)
    ) u_a (
        .pixel_clk  (pixel_clk),
        .arstn      (arstn),
        .enable     (enable),
        .pixel_data (pd[7:0]),
        .pixel_vde  (a_vde),
        .pixel_vs   (a_vs),
        .sig        (a_if.master),
        .overrun    (a_ovr)
    );

    video_frame_signature #(
        .NUM_CH(3), .CH_WIDTH(4), .H_ACTIVE(B_H), .V_ACTIVE(B_V)
    ) u_b (
        .pixel_clk  (pixel_clk),
        .arstn      (arstn),
        .enable     (enable),
        .pixel_data (pd),
        .pixel_vde  (b_vde),
        .pixel_vs   (b_vs),
        .sig        (b_if.master),
        .overrun    (b_ovr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pixels and line lengths of the frame currently being sent.
    int cur_pix[$];
    int cur_lens[$];
    int fixed[$];

    logic [31:0] exp_crc;
    int          exp_pix;
    int          exp_lines;
    logic [2:0]  exp_err;

    // Sampled outputs of the selected instance.
    logic        gv, go;
    logic [31:0] gc;
    int          gp, gl;
    logic [2:0]  ge;

    function automatic logic [31:0] ref_crc(input int w, input int pix[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (pix[k]) begin
            for (int b = w - 1; b >= 0; b--) begin
                fb = c[31] ^ pix[k][b];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        return c;
    endfunction

    task automatic compute_expect();
        int h, v, w, pmax, lmax, total;
        logic bad_len;
        w     = (dsel == 0) ? 8 : 12;
        h     = (dsel == 0) ? A_H : B_H;
        v     = (dsel == 0) ? A_V : B_V;
        pmax  = (1 << ($clog2(h * v + 1) + 1)) - 1;
        lmax  = (1 << ($clog2(v + 1) + 1)) - 1;
        total = cur_pix.size();
        exp_crc   = ref_crc(w, cur_pix);
        exp_pix   = (total > pmax) ? pmax : total;
        exp_lines = (cur_lens.size() > lmax) ? lmax : cur_lens.size();
        bad_len   = 1'b0;
        foreach (cur_lens[k]) if (cur_lens[k] != h) bad_len = 1'b1;
        exp_err   = {total > pmax, exp_lines != v, bad_len};
        cur_pix.delete();
        cur_lens.delete();
    endtask

    task automatic drop_frame();
        cur_pix.delete();
        cur_lens.delete();
    endtask

    task automatic sample();
        if (dsel == 0) begin
            gv = a_if.sig_valid; gc = a_if.sig_crc; gp = int'(a_if.sig_pixels);
            gl = int'(a_if.sig_lines); ge = a_if.sig_geom_err; go = a_ovr;
        end else begin
            gv = b_if.sig_valid; gc = b_if.sig_crc; gp = int'(b_if.sig_pixels);
            gl = int'(b_if.sig_lines); ge = b_if.sig_geom_err; go = b_ovr;
        end
    endtask

    task automatic send_line(input int len);
        int wmask;
        wmask = (dsel == 0) ? 'hFF : 'hFFF;
        for (int i = 0; i < len; i++) begin
            @(negedge pixel_clk);
            vde = 1'b1;
            if (fixed.size() > 0) pd = 12'(fixed.pop_front());
            else                  pd = 12'($urandom & wmask);
            cur_pix.push_back(int'(pd));
        end
        cur_lens.push_back(len);
        @(negedge pixel_clk);
        vde = 1'b0;
        repeat (3) @(negedge pixel_clk);
    endtask

    task automatic vs_pulse();
        @(negedge pixel_clk);
        vde = 1'b0;
        vs  = 1'b0;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        vs = 1'b1;
        repeat (3) @(negedge pixel_clk);
    endtask

    task automatic ack();
        @(negedge pixel_clk);
        rdy = 1'b1;
        @(negedge pixel_clk);
        rdy = 1'b0;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        repeat (3) @(negedge pixel_clk);
        n_cmp++;
        if ({a_if.sig_valid, a_if.sig_crc, a_if.sig_pixels, a_if.sig_lines, a_if.sig_geom_err, a_ovr} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: v=%b crc=%h pix=%0d lines=%0d err=%b ovr=%b, want all 0",
                     a_if.sig_valid, a_if.sig_crc, a_if.sig_pixels, a_if.sig_lines, a_if.sig_geom_err, a_ovr);
        end
        n_cmp++;
        if ({b_if.sig_valid, b_if.sig_crc, b_if.sig_pixels, b_if.sig_lines, b_if.sig_geom_err, b_ovr} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: v=%b crc=%h pix=%0d lines=%0d err=%b ovr=%b, want all 0",
                     b_if.sig_valid, b_if.sig_crc, b_if.sig_pixels, b_if.sig_lines, b_if.sig_geom_err, b_ovr);
        end
        arstn = 1'b1;
        repeat (2) @(negedge pixel_clk);
    endtask

    task automatic test_ascii();
        vs_pulse();
        drop_frame();
        sample();
        n_cmp++;
        if (gv !== 1'b0) begin
            n_bad++;
            $display("FAIL open_a: sig_valid=%b after first frame start, want 0", gv);
        end
        for (int i = 0; i < 9; i++) fixed.push_back(8'h31 + i);
        send_line(9);
        vs_pulse();
        drop_frame();
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge} !== {1'b1, 32'h0376_E6E7, 32'd9, 32'd1, 3'b000}) begin
            n_bad++;
            $display("FAIL ascii: got v=%b crc=%h pix=%0d lines=%0d err=%b, want v=1 crc=0376e6e7 pix=9 lines=1 err=000",
                     gv, gc, gp, gl, ge);
        end
        ack();
        sample();
        n_cmp++;
        if (gv !== 1'b0) begin
            n_bad++;
            $display("FAIL ascii_ack: sig_valid=%b after transfer, want 0", gv);
        end
    endtask

    task automatic test_empty_frame();
        vs_pulse();
        drop_frame();
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge} !== {1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'b010}) begin
            n_bad++;
            $display("FAIL empty: got v=%b crc=%h pix=%0d lines=%0d err=%b, want v=1 crc=ffffffff pix=0 lines=0 err=010",
                     gv, gc, gp, gl, ge);
        end
        ack();
    endtask

    task automatic test_saturate();
        send_line(20);
        send_line(20);
        vs_pulse();
        compute_expect();
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge} !== {1'b1, exp_crc, exp_pix, exp_lines, exp_err}) begin
            n_bad++;
            $display("FAIL saturate: got v=%b crc=%h pix=%0d lines=%0d err=%b, want v=1 crc=%h pix=%0d lines=%0d err=%b",
                     gv, gc, gp, gl, ge, exp_crc, exp_pix, exp_lines, exp_err);
        end
        ack();
    endtask

    task automatic test_short_line();
        for (int l = 0; l < B_V; l++) send_line((l == 7) ? B_H - 1 : B_H);
        vs_pulse();
        compute_expect();
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge} !== {1'b1, exp_crc, 32'd191, 32'd12, 3'b001}) begin
            n_bad++;
            $display("FAIL short_line: got v=%b crc=%h pix=%0d lines=%0d err=%b, want v=1 crc=%h pix=191 lines=12 err=001",
                     gv, gc, gp, gl, ge, exp_crc);
        end
        ack();
    endtask

    task automatic test_random_frames();
        int nl;
        for (int f = 0; f < 5; f++) begin
            nl = $urandom_range(B_V - 1, B_V + 1);
            for (int l = 0; l < nl; l++)
                send_line(($urandom_range(0, 3) == 0) ? $urandom_range(B_H - 2, B_H + 2) : B_H);
            vs_pulse();
            compute_expect();
            repeat ($urandom_range(0, 3)) @(negedge pixel_clk);
            sample();
            n_cmp++;
            if ({gv, gc, gp, gl, ge} !== {1'b1, exp_crc, exp_pix, exp_lines, exp_err}) begin
                n_bad++;
                $display("FAIL random_frame%0d: got v=%b crc=%h pix=%0d lines=%0d err=%b, want v=1 crc=%h pix=%0d lines=%0d err=%b",
                         f, gv, gc, gp, gl, ge, exp_crc, exp_pix, exp_lines, exp_err);
            end
            ack();
        end
    endtask

    task automatic test_overrun();
        logic [31:0] c1;
        int          p1, l1;
        logic [2:0]  e1;
        for (int l = 0; l < B_V; l++) send_line(B_H);
        vs_pulse();
        compute_expect();
        c1 = exp_crc; p1 = exp_pix; l1 = exp_lines; e1 = exp_err;
        sample();
        n_cmp++;
        if (go !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_pre: overrun=%b before any drop, want 0", go);
        end
        for (int l = 0; l < B_V - 2; l++) send_line(B_H);
        vs_pulse();
        drop_frame();
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge, go} !== {1'b1, c1, p1, l1, e1, 1'b1}) begin
            n_bad++;
            $display("FAIL overrun_hold: got v=%b crc=%h pix=%0d lines=%0d err=%b ovr=%b, want v=1 crc=%h pix=%0d lines=%0d err=%b ovr=1",
                     gv, gc, gp, gl, ge, go, c1, p1, l1, e1);
        end
        ack();
        sample();
        n_cmp++;
        if ({gv, go} !== 2'b01) begin
            n_bad++;
            $display("FAIL overrun_ack: sig_valid=%b overrun=%b, want valid=0 overrun=1", gv, go);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_line(B_H);
        send_line(B_H);
        @(negedge pixel_clk);
        vde = 1'b1;
        pd  = 12'($urandom & 'hFFF);
        arstn = 1'b0;
        @(negedge pixel_clk);
        vde = 1'b0;
        arstn = 1'b1;
        drop_frame();
        @(negedge pixel_clk);
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge, go} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got v=%b crc=%h pix=%0d lines=%0d err=%b ovr=%b, want all 0",
                     gv, gc, gp, gl, ge, go);
        end
        vs_pulse();
        drop_frame();
        sample();
        n_cmp++;
        if (gv !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_open: sig_valid=%b at first frame start after reset, want 0", gv);
        end
        for (int l = 0; l < B_V; l++) send_line(B_H);
        vs_pulse();
        compute_expect();
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge} !== {1'b1, exp_crc, exp_pix, exp_lines, exp_err}) begin
            n_bad++;
            $display("FAIL reset_frame: got v=%b crc=%h pix=%0d lines=%0d err=%b, want v=1 crc=%h pix=%0d lines=%0d err=%b",
                     gv, gc, gp, gl, ge, exp_crc, exp_pix, exp_lines, exp_err);
        end
        ack();
        repeat (5) @(negedge pixel_clk);
        sample();
        n_cmp++;
        if (gv !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_single: sig_valid=%b after the only result, want 0", gv);
        end
    endtask

    task automatic test_enable_drop();
        for (int l = 0; l < 5; l++) send_line(B_H);
        enable = 1'b0;
        for (int l = 5; l < B_V; l++) send_line(B_H);
        vs_pulse();
        compute_expect();
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge} !== {1'b1, exp_crc, exp_pix, exp_lines, exp_err}) begin
            n_bad++;
            $display("FAIL en_drop_frame: got v=%b crc=%h pix=%0d lines=%0d err=%b, want v=1 crc=%h pix=%0d lines=%0d err=%b",
                     gv, gc, gp, gl, ge, exp_crc, exp_pix, exp_lines, exp_err);
        end
        ack();
        for (int l = 0; l < 3; l++) send_line(B_H);
        vs_pulse();
        drop_frame();
        sample();
        n_cmp++;
        if (gv !== 1'b0) begin
            n_bad++;
            $display("FAIL en_off_edge: sig_valid=%b with enable low, want 0", gv);
        end
        enable = 1'b1;
        for (int l = 0; l < 3; l++) send_line(B_H);
        vs_pulse();
        drop_frame();
        sample();
        n_cmp++;
        if (gv !== 1'b0) begin
            n_bad++;
            $display("FAIL en_resync: sig_valid=%b on first edge after re-enable, want 0", gv);
        end
        for (int l = 0; l < B_V; l++) send_line(B_H);
        vs_pulse();
        compute_expect();
        sample();
        n_cmp++;
        if ({gv, gc, gp, gl, ge} !== {1'b1, exp_crc, exp_pix, exp_lines, exp_err}) begin
            n_bad++;
            $display("FAIL en_resume: got v=%b crc=%h pix=%0d lines=%0d err=%b, want v=1 crc=%h pix=%0d lines=%0d err=%b",
                     gv, gc, gp, gl, ge, exp_crc, exp_pix, exp_lines, exp_err);
        end
        ack();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        arstn  = 1'b0;
        enable = 1'b1;
        vde    = 1'b0;
        vs     = 1'b1;
        rdy    = 1'b0;
        pd     = '0;
        dsel   = 0;

        test_reset();
        test_ascii();
        test_empty_frame();
        test_saturate();

        dsel = 1;
        @(negedge pixel_clk);
        vs_pulse();
        drop_frame();
        test_short_line();
        test_random_frames();
        test_overrun();
        test_reset_mid_frame();
        test_enable_drop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
